// File: rtl/alu_result_skid.sv
// Registered valid/ready output stage for the ALU: a 2-entry skid buffer
// (output register + one overflow register), sticky status flags and a
// saturating count of delivered results.
module alu_result_skid #(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     y_in,
    input  logic             z_in,
    input  logic             c_in,
    input  logic             v_in,
    input  logic [2:0]       sel_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     y_out,
    output logic             z_out,
    output logic             c_out,
    output logic             v_out,
    output logic [2:0]       sel_out,
    input  logic             clr_sticky,
    output logic             sticky_c,
    output logic             sticky_v,
    output logic             sticky_ill,
    output logic [CNT_W-1:0] result_count
);

    localparam int unsigned PW = N + 6;
    localparam logic [2:0] SEL_MAX = 3'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [PW-1:0] in_word;
    logic [PW-1:0] or_data;
    logic [PW-1:0] sr_data;
    logic          sr_valid;
    logic          acc;
    logic          dlv;

    // Next-state decisions for the two storage slots
    logic          or_load_in;
    logic          or_load_sr;
    logic          sr_load;
    logic          sr_valid_n;
    logic          out_valid_n;

    assign in_word = {sel_in, v_in, c_in, z_in, y_in};
    assign acc     = in_valid && in_ready;
    assign dlv     = out_valid && out_ready;

    assign {sel_out, v_out, c_out, z_out, y_out} = or_data;

    // Decide where an incoming result goes and how the slots advance
    always_comb begin
        or_load_in  = 1'b0;
        or_load_sr  = 1'b0;
        sr_load     = 1'b0;
        sr_valid_n  = sr_valid;
        out_valid_n = out_valid;
        if (sr_valid) begin
            if (dlv) begin
                or_load_sr = 1'b1;
                sr_valid_n = 1'b0;
            end
        end else if (acc) begin
            if (!out_valid || dlv) begin
                or_load_in  = 1'b1;
                out_valid_n = 1'b1;
            end else begin
                sr_load    = 1'b1;
                sr_valid_n = 1'b1;
            end
        end else if (dlv) begin
            out_valid_n = 1'b0;
        end
    end

    // Output and skid registers; in_ready is the registered inverse of skid occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sr_valid  <= 1'b0;
            in_ready  <= 1'b0;
            or_data   <= '0;
            sr_data   <= '0;
        end else begin
            out_valid <= out_valid_n;
            sr_valid  <= sr_valid_n;
            in_ready  <= !sr_valid_n;
            if (or_load_in) begin
                or_data <= in_word;
            end else if (or_load_sr) begin
                or_data <= sr_data;
            end
            if (sr_load) begin
                sr_data <= in_word;
            end
        end
    end

    // Sticky status: a new event in the same cycle wins over a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_c   <= 1'b0;
            sticky_v   <= 1'b0;
            sticky_ill <= 1'b0;
        end else begin
            sticky_c   <= (sticky_c && !clr_sticky) || (acc && c_in);
            sticky_v   <= (sticky_v && !clr_sticky) || (acc && v_in);
            sticky_ill <= (sticky_ill && !clr_sticky) || (acc && (sel_in > SEL_MAX));
        end
    end

    // Saturating count of output handshakes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_count <= '0;
        end else if (dlv && (result_count != CNT_MAX)) begin
            result_count <= result_count + CNT_W'(1);
        end
    end

endmodule
